// File: rtl/cp0_excp_ctrl_pkg.sv
// +------------------------------------------------------------------------+
// | cp0_excp_ctrl_pkg : shared CP0 exception constants and priority picker |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

package cp0_excp_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Status register bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // commit_excp bit indices
  localparam int EX_ADES    = 0;
  localparam int EX_ADEL_LD = 1;
  localparam int EX_OV      = 2;
  localparam int EX_BP      = 3;
  localparam int EX_SYS     = 4;
  localparam int EX_RI      = 5;
  localparam int EX_ADEL_IF = 6;

  typedef enum logic [1:0] {BV_NONE = 2'd0, BV_PC = 2'd1, BV_ADDR = 2'd2} badv_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    badv_sel_e  badv;
  } exc_sel_t;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

  function automatic exc_sel_t pick_exc(input logic int_req, input logic [6:0] excp);
    exc_sel_t s;
    s.valid = 1'b1;
    s.code  = EXC_INT;
    s.badv  = BV_NONE;
    if (int_req) begin
      s.code = EXC_INT;
    end else if (excp[EX_ADEL_IF]) begin
      s.code = EXC_ADEL;
      s.badv = BV_PC;
    end else if (excp[EX_RI]) begin
      s.code = EXC_RI;
    end else if (excp[EX_SYS]) begin
      s.code = EXC_SYS;
    end else if (excp[EX_BP]) begin
      s.code = EXC_BP;
    end else if (excp[EX_OV]) begin
      s.code = EXC_OV;
    end else if (excp[EX_ADEL_LD]) begin
      s.code = EXC_ADEL;
      s.badv = BV_ADDR;
    end else if (excp[EX_ADES]) begin
      s.code = EXC_ADES;
      s.badv = BV_ADDR;
    end else begin
      s.valid = 1'b0;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_excp_ctrl_if.sv
// +------------------------------------------------------------------------+
// | cp0_excp_ctrl_if : commit/CP0 side signals of the exception controller |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

interface cp0_excp_ctrl_if #(
  parameter int HW_INT_W = 6
);
  logic [31:0]         status_data;
  logic [31:0]         epc_data;
  logic [1:0]          cause_ip_sw;
  logic [HW_INT_W-1:0] hw_int;
  logic                timer_int;
  logic                commit_valid;
  logic [31:0]         commit_pc;
  logic                commit_in_ds;
  logic [6:0]          commit_excp;
  logic [31:0]         commit_badvaddr;
  logic                commit_eret;

  logic                exception;
  logic                eret_op;
  logic [4:0]          exc_code;
  logic                cause_bd;
  logic [5:0]          cause_ip_hw;
  logic                epc_we;
  logic [31:0]         epc_o;
  logic                badvaddr_we;
  logic [31:0]         badvaddr_o;
  logic                flush;
  logic [31:0]         flush_pc;

  modport master (
    output status_data, epc_data, cause_ip_sw, hw_int, timer_int,
           commit_valid, commit_pc, commit_in_ds, commit_excp,
           commit_badvaddr, commit_eret,
    input  exception, eret_op, exc_code, cause_bd, cause_ip_hw, epc_we,
           epc_o, badvaddr_we, badvaddr_o, flush, flush_pc
  );

  modport slave (
    input  status_data, epc_data, cause_ip_sw, hw_int, timer_int,
           commit_valid, commit_pc, commit_in_ds, commit_excp,
           commit_badvaddr, commit_eret,
    output exception, eret_op, exc_code, cause_bd, cause_ip_hw, epc_we,
           epc_o, badvaddr_we, badvaddr_o, flush, flush_pc
  );
endinterface

`default_nettype wire

// File: rtl/cp0_excp_ctrl_int_sync.sv
// +------------------------------------------------------------------------+
// | cp0_int_sync : per-bit flop-chain synchroniser for async interrupts    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module cp0_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [STAGES-1:0] r_chain;
      always_ff @(posedge clk) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[STAGES-2:0], d[i]};
      end
      assign q[i] = r_chain[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cp0_excp_ctrl.sv
// +------------------------------------------------------------------------+
// | cp0_excp_ctrl : prioritises one exception/interrupt/ERET per commit    |
// | and issues registered CP0 update strobes plus a one-cycle flush.       |
// | Optional macro: CP0_TIMER_INT_EN (timer_int ORed into IP7).            |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module cp0_excp_ctrl
  import cp0_excp_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          HW_INT_W    = 6,
  parameter int          SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  cp0_excp_ctrl_if.slave   bus
);

  logic [HW_INT_W-1:0] w_hw_sync;
  logic [5:0]          w_ip_raw;
  logic [5:0]          w_ip_hw;

  cp0_int_sync #(.WIDTH(HW_INT_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.hw_int),
    .q     (w_hw_sync)
  );

  generate
    for (genvar i = 0; i < 6; i++) begin : g_ip
      if (i < HW_INT_W) begin : g_hw
        assign w_ip_raw[i] = w_hw_sync[i];
      end else begin : g_zero
        assign w_ip_raw[i] = 1'b0;
      end
    end
  endgenerate

`ifdef CP0_TIMER_INT_EN
  assign w_ip_hw = {w_ip_raw[5] | bus.timer_int, w_ip_raw[4:0]};
`else
  logic unused_timer;
  assign unused_timer = bus.timer_int;
  assign w_ip_hw      = w_ip_raw;
`endif

  assign bus.cause_ip_hw = w_ip_hw;

  logic [31:0] w_st;
  logic [7:0]  w_ip;
  logic        w_int_req;
  exc_sel_t    w_sel;
  logic        unused_status;

  assign w_st          = bus.status_data;
  assign unused_status = ^{w_st[31:ST_BEV+1], w_st[ST_BEV], w_st[ST_BEV-1:ST_IM_HI+1],
                           w_st[ST_IM_LO-1:ST_EXL+1]};
  assign w_ip          = {w_ip_hw, bus.cause_ip_sw};
  assign w_int_req     = w_st[ST_IE] & ~w_st[ST_EXL] & (|(w_ip & w_st[ST_IM_HI:ST_IM_LO]));
  assign w_sel         = pick_exc(w_int_req, bus.commit_excp);

  state_e      r_state, n_state;
  logic        r_exc, n_exc, r_eret, n_eret, r_bd, n_bd;
  logic        r_epc_we, n_epc_we, r_bv_we, n_bv_we, r_flush, n_flush;
  logic [4:0]  r_code, n_code;
  logic [31:0] r_epc, n_epc, r_bv, n_bv, r_fpc, n_fpc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_exc    <= 1'b0;
      r_eret   <= 1'b0;
      r_bd     <= 1'b0;
      r_epc_we <= 1'b0;
      r_bv_we  <= 1'b0;
      r_flush  <= 1'b0;
      r_code   <= '0;
      r_epc    <= '0;
      r_bv     <= '0;
      r_fpc    <= '0;
    end else begin
      r_state  <= n_state;
      r_exc    <= n_exc;
      r_eret   <= n_eret;
      r_bd     <= n_bd;
      r_epc_we <= n_epc_we;
      r_bv_we  <= n_bv_we;
      r_flush  <= n_flush;
      r_code   <= n_code;
      r_epc    <= n_epc;
      r_bv     <= n_bv;
      r_fpc    <= n_fpc;
    end
  end

  // Non-event cycles drive every strobe and data field to zero.
  always_comb begin
    n_state  = r_state;
    n_exc    = 1'b0;
    n_eret   = 1'b0;
    n_bd     = 1'b0;
    n_epc_we = 1'b0;
    n_bv_we  = 1'b0;
    n_flush  = 1'b0;
    n_code   = '0;
    n_epc    = '0;
    n_bv     = '0;
    n_fpc    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.commit_valid) begin
          if (w_sel.valid) begin
            n_state  = S_FLUSH;
            n_exc    = 1'b1;
            n_flush  = 1'b1;
            n_fpc    = EXC_VECTOR;
            n_code   = w_sel.code;
            n_bd     = bus.commit_in_ds;
            n_epc_we = ~w_st[ST_EXL];
            n_epc    = bus.commit_in_ds ? bus.commit_pc - 32'd4 : bus.commit_pc;
            if (w_sel.badv == BV_PC) begin
              n_bv_we = 1'b1;
              n_bv    = bus.commit_pc;
            end else if (w_sel.badv == BV_ADDR) begin
              n_bv_we = 1'b1;
              n_bv    = bus.commit_badvaddr;
            end
          end else if (bus.commit_eret) begin
            n_state = S_FLUSH;
            n_eret  = 1'b1;
            n_flush = 1'b1;
            n_fpc   = bus.epc_data;
          end
        end
      end
      S_FLUSH: n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  assign bus.exception   = r_exc;
  assign bus.eret_op     = r_eret;
  assign bus.exc_code    = r_code;
  assign bus.cause_bd    = r_bd;
  assign bus.epc_we      = r_epc_we;
  assign bus.epc_o       = r_epc;
  assign bus.badvaddr_we = r_bv_we;
  assign bus.badvaddr_o  = r_bv;
  assign bus.flush       = r_flush;
  assign bus.flush_pc    = r_fpc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_excp_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_cp0_excp_ctrl : directed and random checks against a behavioural    |
// | model of the CP0 exception controller.                                 |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_cp0_excp_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cp0_excp_ctrl_if #(.HW_INT_W(6)) bus ();

  cp0_excp_ctrl #(.EXC_VECTOR(VEC), .HW_INT_W(6), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ExcCode per commit_excp bit, bit 0 (AdES) .. bit 6 (AdEL_if)
  int code_of [7] = '{5, 4, 12, 9, 8, 10, 4};

  // model state: two-cycle interrupt delay line, and "one event just issued"
  logic [5:0] dly [2];
  logic       busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.commit_valid    = 1'b0;
    bus.commit_excp     = 7'h0;
    bus.commit_eret     = 1'b0;
    bus.commit_in_ds    = 1'b0;
    bus.commit_pc       = 32'h0;
    bus.commit_badvaddr = 32'h0;
  endtask

  task automatic cycle();
    logic [5:0]  iph;
    logic [7:0]  ip;
    logic        intr, any, dec, exc, er, e_bd, e_epcwe, e_bvwe;
    int          first;
    logic [4:0]  e_code;
    logic [31:0] e_epc, e_bv, e_fpc;
    logic [5:0]  hw_s;
    iph = dly[1];
`ifdef CP0_TIMER_INT_EN
    iph[5] = iph[5] | bus.timer_int;
`endif
    ip    = {iph, bus.cause_ip_sw};
    dec   = rst_n && !busy && bus.commit_valid;
    intr  = bus.status_data[0] && !bus.status_data[1] && ((ip & bus.status_data[15:8]) != 8'h0);
    first = -1;
    for (int b = 6; b >= 0; b--) if (first < 0 && bus.commit_excp[b]) first = b;
    any = intr || (first >= 0);
    exc = dec && any;
    er  = dec && !any && bus.commit_eret;
    e_code = 5'd0; e_bd = 1'b0; e_epcwe = 1'b0; e_bvwe = 1'b0;
    e_epc = 32'h0; e_bv = 32'h0; e_fpc = 32'h0;
    if (exc) begin
      e_fpc   = VEC;
      e_bd    = bus.commit_in_ds;
      e_epc   = bus.commit_in_ds ? bus.commit_pc - 32'd4 : bus.commit_pc;
      e_epcwe = !bus.status_data[1];
      if (!intr) begin
        e_code = 5'(code_of[first]);
        if (first == 6) begin
          e_bvwe = 1'b1; e_bv = bus.commit_pc;
        end else if (first <= 1) begin
          e_bvwe = 1'b1; e_bv = bus.commit_badvaddr;
        end
      end
    end else if (er) begin
      e_fpc = bus.epc_data;
    end
    hw_s = bus.hw_int;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      dly[0] = 6'h0; dly[1] = 6'h0; busy = 1'b0;
    end else begin
      dly[1] = dly[0]; dly[0] = hw_s; busy = exc || er;
    end
    iph = dly[1];
`ifdef CP0_TIMER_INT_EN
    iph[5] = iph[5] | bus.timer_int;
`endif
    chk("exception",   32'(bus.exception),   32'(exc));
    chk("eret_op",     32'(bus.eret_op),     32'(er));
    chk("flush",       32'(bus.flush),       32'(exc || er));
    chk("flush_pc",    bus.flush_pc,         e_fpc);
    chk("exc_code",    32'(bus.exc_code),    32'(e_code));
    chk("cause_bd",    32'(bus.cause_bd),    32'(e_bd));
    chk("epc_we",      32'(bus.epc_we),      32'(e_epcwe));
    chk("epc_o",       bus.epc_o,            e_epc);
    chk("badvaddr_we", 32'(bus.badvaddr_we), 32'(e_bvwe));
    chk("badvaddr_o",  bus.badvaddr_o,       e_bv);
    chk("cause_ip_hw", 32'(bus.cause_ip_hw), 32'(iph));
  endtask

  initial begin
    dly[0] = 6'h0; dly[1] = 6'h0; busy = 1'b0;
    rst_n = 1'b0;
    bus.status_data = 32'h0; bus.epc_data = 32'h0; bus.cause_ip_sw = 2'b0;
    bus.hw_int = 6'h0; bus.timer_int = 1'b0;
    set_idle();
    cycle(); cycle();
    chk("rst_flush", 32'(bus.flush), 32'h0);
    rst_n = 1'b1;

    // interrupt through the synchroniser
    bus.status_data = 32'h0000_0401; bus.hw_int = 6'h01;
    cycle(); cycle(); cycle();
    bus.commit_valid = 1'b1; bus.commit_pc = 32'h8000_0100;
    cycle();
    chk("tp1_exception", 32'(bus.exception), 32'h1);
    chk("tp1_code",      32'(bus.exc_code),  32'h0);
    chk("tp1_epc",       bus.epc_o,          32'h8000_0100);
    chk("tp1_fpc",       bus.flush_pc,       32'hBFC0_0380);
    set_idle(); bus.hw_int = 6'h0; bus.status_data = 32'h0;
    cycle();

    // RI beats Ov, delay slot
    bus.commit_valid = 1'b1; bus.commit_excp = 7'b0100100;
    bus.commit_in_ds = 1'b1; bus.commit_pc = 32'h8000_0204;
    cycle();
    chk("tp2_code", 32'(bus.exc_code),    32'd10);
    chk("tp2_bd",   32'(bus.cause_bd),    32'h1);
    chk("tp2_epc",  bus.epc_o,            32'h8000_0200);
    chk("tp2_bvwe", 32'(bus.badvaddr_we), 32'h0);
    set_idle(); cycle();

    // AdES
    bus.commit_valid = 1'b1; bus.commit_excp = 7'b0000001; bus.commit_badvaddr = 32'h0000_0003;
    cycle();
    chk("tp3_code", 32'(bus.exc_code),    32'd5);
    chk("tp3_bvwe", 32'(bus.badvaddr_we), 32'h1);
    chk("tp3_bv",   bus.badvaddr_o,       32'h0000_0003);
    set_idle(); cycle();

    // ERET alone, then ERET with Sys
    bus.epc_data = 32'h8000_0340;
    bus.commit_valid = 1'b1; bus.commit_eret = 1'b1;
    cycle();
    chk("tp4_eret", 32'(bus.eret_op),   32'h1);
    chk("tp4_fpc",  bus.flush_pc,       32'h8000_0340);
    chk("tp4_exc",  32'(bus.exception), 32'h0);
    set_idle(); cycle();
    bus.commit_valid = 1'b1; bus.commit_eret = 1'b1; bus.commit_excp = 7'b0010000;
    cycle();
    chk("tp4b_exc",  32'(bus.exception), 32'h1);
    chk("tp4b_code", 32'(bus.exc_code),  32'd8);
    chk("tp4b_eret", 32'(bus.eret_op),   32'h0);
    set_idle(); cycle();

    // EXL set: EPC preserved; pending interrupt masked
    bus.status_data = 32'h0000_0002;
    bus.commit_valid = 1'b1; bus.commit_excp = 7'b0010000;
    cycle();
    chk("tp5_exc",   32'(bus.exception), 32'h1);
    chk("tp5_epcwe", 32'(bus.epc_we),    32'h0);
    set_idle(); cycle();
    bus.status_data = 32'h0000_0403; bus.hw_int = 6'h01;
    cycle(); cycle(); cycle();
    bus.commit_valid = 1'b1;
    cycle();
    chk("tp5b_exc",   32'(bus.exception), 32'h0);
    chk("tp5b_flush", 32'(bus.flush),     32'h0);
    set_idle(); bus.hw_int = 6'h0; bus.status_data = 32'h0;
    cycle();

    // back-to-back Bp commits give a single event
    bus.commit_valid = 1'b1; bus.commit_excp = 7'b0001000;
    cycle();
    chk("tp6_first",  32'(bus.exception), 32'h1);
    cycle();
    chk("tp6_second", 32'(bus.exception), 32'h0);
    set_idle(); cycle();

    // reset while in FLUSH
    bus.commit_valid = 1'b1; bus.commit_excp = 7'b0001000;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("tp6_rst_flush", 32'(bus.flush), 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("tp6_after_rst", 32'(bus.exception), 32'h1);
    set_idle(); cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        bus.status_data    = $urandom;
        bus.status_data[1] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) bus.hw_int = 6'($urandom);
      bus.cause_ip_sw     = 2'($urandom);
      bus.timer_int       = 1'($urandom);
      bus.epc_data        = $urandom;
      bus.commit_valid    = ($urandom_range(0, 9) < 7);
      bus.commit_pc       = $urandom;
      bus.commit_in_ds    = 1'($urandom);
      bus.commit_badvaddr = $urandom;
      bus.commit_eret     = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 1)      bus.commit_excp = 7'(7'd1 << $urandom_range(0, 6));
      else if (r == 2) bus.commit_excp = 7'($urandom);
      else             bus.commit_excp = 7'h0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
